// File: rtl/flag_sync_stretch_if.sv
// Flag receiver bus: asynchronous flag inputs, overflow clears and the per-channel
// synchronised/edge/stretched outputs of flag_sync_stretch.
interface flag_sync_stretch_if #(
    parameter int unsigned CHANNELS = 4
) ();

    logic [CHANNELS-1:0] flag_async_in;
    logic [CHANNELS-1:0] ovf_clear;
    logic [CHANNELS-1:0] level_out;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;
    logic [CHANNELS-1:0] stretched_out;
    logic [CHANNELS-1:0] overflow;
    logic                any_active;

    // Sender side: drives the flags and clears, observes the receiver outputs.
    modport master (
        output flag_async_in,
        output ovf_clear,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  stretched_out,
        input  overflow,
        input  any_active
    );

    // Receiver side: the flag_sync_stretch block itself.
    modport slave (
        input  flag_async_in,
        input  ovf_clear,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output stretched_out,
        output overflow,
        output any_active
    );

endinterface

// File: rtl/flag_sync_stretch.sv
// Multi-channel asynchronous flag receiver: synchroniser chain, edge detector and
// programmable pulse stretcher with optional retrigger and sticky overflow per channel.
module flag_sync_stretch #(
    parameter int unsigned         CHANNELS    = 4,
    parameter int unsigned         SYNC_STAGES = 3,
    parameter int unsigned         STRETCH     = 8,
    parameter bit                  RETRIGGER   = 1'b1,
    parameter logic [CHANNELS-1:0] INIT_STATE  = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    flag_sync_stretch_if.slave bus
);

    localparam int unsigned      CNT_W    = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_last_c;
    logic [CHANNELS-1:0] hist_q;
    logic [CHANNELS-1:0] rise_c;
    logic [CHANNELS-1:0] fall_c;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] stretch_q;
    logic [CHANNELS-1:0] stretch_d;
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ovf_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic                any_active_q;

    // Plain flop chain; nothing may sit between stages or metastability settling suffers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT_STATE;
            end
        end else begin
            sync_q[0] <= bus.flag_async_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_last_c = sync_q[SYNC_STAGES-1];
    assign rise_c      = sync_last_c & ~hist_q;
    assign fall_c      = ~sync_last_c & hist_q;

    // History resets to the chain value, so reset release never produces an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= INIT_STATE;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            hist_q <= sync_last_c;
            rise_q <= rise_c;
            fall_q <= fall_c;
        end
    end

    // Stretcher next state; an active channel includes its final cnt==0 cycle.
    always_comb begin
        stretch_d = stretch_q;
        ovf_d     = ovf_q & ~bus.ovf_clear;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!stretch_q[i]) begin
                if (rise_c[i]) begin
                    stretch_d[i] = 1'b1;
                    cnt_d[i]     = CNT_LOAD;
                end
            end else if (rise_c[i] && RETRIGGER) begin
                cnt_d[i] = CNT_LOAD;
            end else begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end else begin
                    stretch_d[i] = 1'b0;
                end
                // A dropped rise sets overflow; this wins over a same-cycle clear.
                if (rise_c[i]) begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stretch_q    <= '0;
            ovf_q        <= '0;
            any_active_q <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stretch_q    <= stretch_d;
            ovf_q        <= ovf_d;
            any_active_q <= |stretch_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.level_out     = sync_last_c;
    assign bus.rise_pulse    = rise_q;
    assign bus.fall_pulse    = fall_q;
    assign bus.stretched_out = stretch_q;
    assign bus.overflow      = ovf_q;
    assign bus.any_active    = any_active_q;

endmodule
